ofdm_frame_extractor: RTL and testbench

//  Runtime-configurable OFDM frame extractor; sits between the packet detector/sync stage and the FFT.

---
 rtl/ofdm_frame_extractor.sv | 195 +++++++++++++++++++
 tb/tb_ofdm_frame_extractor.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofdm_frame_extractor.sv
// OFDM frame extractor between packet detection and the FFT: after a detector tlast it drops
// the gap, passes long-preamble symbols, strips each cyclic prefix and passes N data symbols.
module ofdm_frame_extractor #(
  parameter int WIDTH             = 32,
  parameter int MAX_SYMBOL_LEN    = 256,
  parameter int MAX_CP_LEN        = 64,
  parameter int MAX_GAP           = 255,
  parameter int MAX_PREAMBLE_SYMS = 4,
  parameter int MAX_NUM_SYMBOLS   = 256,
  localparam int GAP_W = $clog2(MAX_GAP + 1),
  localparam int PRE_W = $clog2(MAX_PREAMBLE_SYMS + 1),
  localparam int CP_W  = $clog2(MAX_CP_LEN + 1),
  localparam int SYM_W = $clog2(MAX_SYMBOL_LEN + 1),
  localparam int NUM_W = $clog2(MAX_NUM_SYMBOLS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [GAP_W-1:0] cfg_gap,
  input  logic [PRE_W-1:0] cfg_preamble_syms,
  input  logic [CP_W-1:0]  cfg_cp_len,
  input  logic [SYM_W-1:0] cfg_sym_len,
  input  logic [NUM_W-1:0] num_symbols,
  input  logic             num_symbols_valid,
  input  logic             abort,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic             o_sof,
  output logic             o_eof,
  output logic             o_is_preamble,
  output logic [NUM_W-1:0] o_sym_idx,
  output logic             o_frame_active
);

  localparam int CNT_W0 = (GAP_W > CP_W) ? GAP_W : CP_W;
  localparam int CNT_W  = (CNT_W0 > SYM_W) ? CNT_W0 : SYM_W;
  localparam int IW     = ((NUM_W > PRE_W) ? NUM_W : PRE_W) + 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_GAP  = 3'd1;
  localparam logic [2:0] S_PRE  = 3'd2;
  localparam logic [2:0] S_CP   = 3'd3;
  localparam logic [2:0] S_SYM  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_W-1:0] sym_idx_q, sym_idx_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CP_W-1:0]  cp_q, cp_d;
  logic [SYM_W-1:0] sym_len_q, sym_len_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic             num_vld_q, num_vld_d;
  logic             sof_pend_q, sof_pend_d;

  logic             pass_st, beat;
  logic [CNT_W-1:0] cnt_inc;
  logic             gap_done, cp_done, sym_last, pre_done, frame_done;
  logic [NUM_W:0]   target;
  logic [NUM_W-1:0] num_clamped;
  logic [2:0]       after_pre, after_gap, cfg_after_pre, cfg_after_gap, cfg_first;

  assign pass_st = (state_q == S_PRE) || (state_q == S_SYM);
  assign i_tready = pass_st ? o_tready : 1'b1;
  assign beat     = i_tvalid & i_tready;

  assign cnt_inc    = cnt_q + CNT_W'(1);
  assign gap_done   = cnt_inc == CNT_W'(gap_q);
  assign cp_done    = cnt_inc == CNT_W'(cp_q);
  assign sym_last   = cnt_inc == CNT_W'(sym_len_q);
  assign pre_done   = (IW'(sym_idx_q) + IW'(1)) == IW'(pre_q);
  assign target     = num_vld_q ? {1'b0, num_q} : (NUM_W + 1)'(MAX_NUM_SYMBOLS);
  assign frame_done = ({1'b0, sym_idx_q} + (NUM_W + 1)'(1)) >= target;

  assign num_clamped = (num_symbols == '0) ? NUM_W'(1) :
                       (num_symbols > NUM_W'(MAX_NUM_SYMBOLS)) ? NUM_W'(MAX_NUM_SYMBOLS) :
                       num_symbols;

  // Skip empty phases so the frame jumps straight to the first non-empty one.
  assign after_pre     = (cp_q != '0) ? S_CP : S_SYM;
  assign after_gap     = (pre_q != '0) ? S_PRE : after_pre;
  assign cfg_after_pre = (cfg_cp_len != '0) ? S_CP : S_SYM;
  assign cfg_after_gap = (cfg_preamble_syms != '0) ? S_PRE : cfg_after_pre;
  assign cfg_first     = (cfg_gap != '0) ? S_GAP : cfg_after_gap;

  assign o_tdata        = i_tdata;
  assign o_tvalid       = pass_st & i_tvalid;
  assign o_tlast        = pass_st & sym_last;
  assign o_sof          = pass_st & sof_pend_q;
  assign o_eof          = (state_q == S_SYM) & sym_last & frame_done & ~abort;
  assign o_is_preamble  = (state_q == S_PRE);
  assign o_sym_idx      = sym_idx_q;
  assign o_frame_active = (state_q != S_IDLE);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sym_idx_d  = sym_idx_q;
    gap_d      = gap_q;
    pre_d      = pre_q;
    cp_d       = cp_q;
    sym_len_d  = sym_len_q;
    num_d      = num_q;
    num_vld_d  = num_vld_q;
    sof_pend_d = sof_pend_q;

    if (state_q != S_IDLE && num_symbols_valid && !num_vld_q) begin
      num_vld_d = 1'b1;
      num_d     = num_clamped;
    end

    case (state_q)
      S_IDLE: if (beat && i_tlast) begin
        gap_d      = cfg_gap;
        pre_d      = cfg_preamble_syms;
        cp_d       = cfg_cp_len;
        sym_len_d  = (cfg_sym_len == '0) ? SYM_W'(1) : cfg_sym_len;
        num_vld_d  = 1'b0;
        cnt_d      = '0;
        sym_idx_d  = '0;
        sof_pend_d = 1'b1;
        state_d    = cfg_first;
      end
      S_GAP: if (beat) begin
        cnt_d = gap_done ? '0 : cnt_inc;
        if (gap_done) state_d = after_gap;
      end
      S_PRE: if (beat) begin
        sof_pend_d = 1'b0;
        cnt_d      = sym_last ? '0 : cnt_inc;
        if (sym_last) begin
          sym_idx_d = pre_done ? '0 : sym_idx_q + NUM_W'(1);
          if (pre_done) state_d = after_pre;
        end
      end
      S_CP: if (beat) begin
        cnt_d = cp_done ? '0 : cnt_inc;
        if (cp_done) state_d = S_SYM;
      end
      S_SYM: if (beat) begin
        sof_pend_d = 1'b0;
        cnt_d      = sym_last ? '0 : cnt_inc;
        if (sym_last) begin
          if (frame_done) begin
            state_d = S_IDLE;
          end else begin
            sym_idx_d = sym_idx_q + NUM_W'(1);
            state_d   = (cp_q != '0) ? S_CP : S_SYM;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over every transition; the beat of this cycle has already been handled above.
    if (abort) begin
      state_d    = S_IDLE;
      cnt_d      = '0;
      sym_idx_d  = '0;
      sof_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      sym_idx_q  <= '0;
      gap_q      <= '0;
      pre_q      <= '0;
      cp_q       <= '0;
      sym_len_q  <= '0;
      num_q      <= '0;
      num_vld_q  <= 1'b0;
      sof_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sym_idx_q  <= sym_idx_d;
      gap_q      <= gap_d;
      pre_q      <= pre_d;
      cp_q       <= cp_d;
      sym_len_q  <= sym_len_d;
      num_q      <= num_d;
      num_vld_q  <= num_vld_d;
      sof_pend_q <= sof_pend_d;
    end
  end

endmodule

// File: tb/tb_ofdm_frame_extractor.sv
// Scoreboard bench for ofdm_frame_extractor: a segment-level frame model predicts every passed
// beat from its input-beat index; a monitor pops and compares on each output handshake.
module tb_ofdm_frame_extractor;
  localparam int W    = 32;
  localparam int MAXN = 8;
  localparam int NW   = $clog2(MAXN + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    cfg_gap = '0;
  logic [2:0]    cfg_preamble_syms = '0;
  logic [6:0]    cfg_cp_len = '0;
  logic [8:0]    cfg_sym_len = '0;
  logic [NW-1:0] num_symbols = '0;
  logic          num_symbols_valid = 1'b0;
  logic          abort = 1'b0;
  logic [W-1:0]  i_tdata = '0;
  logic          i_tlast = 1'b0;
  logic          i_tvalid = 1'b0;
  logic          i_tready;
  logic [W-1:0]  o_tdata;
  logic          o_tlast, o_tvalid, o_sof, o_eof, o_is_preamble, o_frame_active;
  logic          o_tready = 1'b1;
  logic [NW-1:0] o_sym_idx;

  always #5 clk = ~clk;

  ofdm_frame_extractor #(.WIDTH(W), .MAX_NUM_SYMBOLS(MAXN)) dut (
    .clk(clk), .reset(reset),
    .cfg_gap(cfg_gap), .cfg_preamble_syms(cfg_preamble_syms), .cfg_cp_len(cfg_cp_len),
    .cfg_sym_len(cfg_sym_len), .num_symbols(num_symbols), .num_symbols_valid(num_symbols_valid),
    .abort(abort),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .o_sof(o_sof), .o_eof(o_eof), .o_is_preamble(o_is_preamble), .o_sym_idx(o_sym_idx),
    .o_frame_active(o_frame_active)
  );

  typedef struct packed {
    logic [W-1:0]  data;
    logic          last;
    logic          sof;
    logic          eof;
    logic          pre;
    logic [NW-1:0] idx;
  } beat_t;

  typedef struct {
    string       name;
    logic [63:0] act;
    logic [63:0] exp;
  } chk_t;

  beat_t sb[$];
  chk_t  cq[$];
  int    n_cmp = 0;
  int    n_fail = 0;
  bit    rdy_rand = 0;

  bit    pl_pass[1024];
  beat_t pl_exp[1024];
  int    end_k;

  // Direct checks are queued here and evaluated by the monitor, the only writer of the counters.
  task automatic post_chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_t c;
    c.name = name; c.act = act; c.exp = exp;
    cq.push_back(c);
  endtask

  beat_t mon_act, mon_exp;
  chk_t  mon_c;
  always @(negedge clk) begin
    while (cq.size() > 0) begin
      mon_c = cq.pop_front();
      n_cmp++;
      if (mon_c.act !== mon_c.exp) begin
        n_fail++;
        $display("FAIL %s: got %0h required %0h", mon_c.name, mon_c.act, mon_c.exp);
      end
    end
    if (!reset && o_tvalid && o_tready) begin
      mon_act.data = o_tdata; mon_act.last = o_tlast; mon_act.sof = o_sof;
      mon_act.eof = o_eof; mon_act.pre = o_is_preamble; mon_act.idx = o_sym_idx;
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL out_extra: got %h (data|last|sof|eof|pre|idx) required no output", mon_act);
      end else begin
        mon_exp = sb.pop_front();
        if (mon_act !== mon_exp) begin
          n_fail++;
          $display("FAIL out_beat: got %h required %h (data|last|sof|eof|pre|idx)", mon_act, mon_exp);
        end
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    o_tready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic int clampn(input int v);
    if (v == 0) return 1;
    if (v > MAXN) return MAXN;
    return v;
  endfunction

  function automatic void set_exp(input int k, input bit l, input bit sof, input bit eof,
                                  input bit pre, input int idx);
    pl_pass[k]       = 1'b1;
    pl_exp[k].data   = '0;
    pl_exp[k].last   = l;
    pl_exp[k].sof    = sof;
    pl_exp[k].eof    = eof;
    pl_exp[k].pre    = pre;
    pl_exp[k].idx    = NW'(idx);
  endfunction

  // Frame as segments over post-trigger input beats: gap, preamble symbols, then (cp, symbol)*.
  // A strobe issued before beat sk governs every symbol boundary at beat index >= sk.
  task automatic build_plan(input int g, input int p, input int c, input int sraw,
                            input int ns, input int sk0, input int sv0);
    int s, k, tgt;
    bit first, done, eof;
    for (int i = 0; i < 1024; i++) pl_pass[i] = 1'b0;
    s = (sraw == 0) ? 1 : sraw;
    k = g;
    first = 1'b1;
    for (int ps = 0; ps < p; ps++)
      for (int n = 0; n < s; n++) begin
        set_exp(k, n == s - 1, first, 1'b0, 1'b1, ps);
        first = 1'b0;
        k++;
      end
    done = 1'b0;
    for (int j = 0; !done; j++) begin
      k += c;
      for (int n = 0; n < s; n++) begin
        eof = 1'b0;
        if (n == s - 1) begin
          tgt  = (ns > 0 && sk0 <= k) ? clampn(sv0) : MAXN;
          done = (j + 1 >= tgt);
          eof  = done;
        end
        set_exp(k, n == s - 1, first, eof, 1'b0, j);
        first = 1'b0;
        k++;
      end
    end
    end_k = k;
  endtask

  task automatic do_beat(input logic [W-1:0] d, input logic l);
    int w;
    w = 0;
    i_tdata = d; i_tlast = l; i_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (i_tready) break;
      w++;
      if (w > 500) begin
        post_chk("beat_timeout", 64'd1, 64'd0);
        break;
      end
    end
    @(posedge clk); #1;
    i_tvalid = 1'b0;
  endtask

  task automatic do_strobe(input int v);
    i_tvalid = 1'b0;
    num_symbols = NW'(v);
    num_symbols_valid = 1'b1;
    @(posedge clk); #1;
    num_symbols_valid = 1'b0;
    num_symbols = NW'($urandom);
  endtask

  task automatic do_kill(input int kind);
    i_tvalid = 1'b0;
    if (kind == 2) reset = 1'b1; else abort = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; abort = 1'b0;
    i_tvalid = 1'b1; i_tlast = 1'b0;
    #1;
    post_chk(kind == 2 ? "reset_frame_active" : "abort_frame_active", 64'(o_frame_active), 64'd0);
    if (kind == 2) begin
      post_chk("reset_o_tvalid", 64'(o_tvalid), 64'd0);
      post_chk("reset_i_tready", 64'(i_tready), 64'd1);
    end
  endtask

  // kill_k: -1 none, -2 random abort; kill_kind 1 = abort, 2 = reset (applied before beat kill_k).
  task automatic run_frame(input int g, input int p, input int c, input int s,
                           input int ns, input int sk0, input int sv0, input int sk1, input int sv1,
                           input int kill_k_in, input int kill_kind, input bit rr);
    int kill_k, lim, total;
    logic [W-1:0] d;
    logic l;
    beat_t e;
    rdy_rand = rr;
    build_plan(g, p, c, s, ns, sk0, sv0);
    kill_k = kill_k_in;
    if (kill_k == -2)
      kill_k = (end_k > 1 && $urandom_range(0, 4) == 0) ? $urandom_range(1, end_k - 1) : -1;
    lim   = (kill_k >= 0 && kill_k < end_k) ? kill_k : end_k;
    total = end_k + 3;
    repeat (2) do_beat($urandom, 1'b0);
    cfg_gap = 8'(g); cfg_preamble_syms = 3'(p); cfg_cp_len = 7'(c); cfg_sym_len = 9'(s);
    do_beat($urandom, 1'b1);
    cfg_gap = 8'($urandom); cfg_preamble_syms = 3'($urandom); cfg_cp_len = 7'($urandom);
    cfg_sym_len = 9'($urandom);
    for (int k = 0; k < total; k++) begin
      if (k == kill_k) do_kill(kill_kind);
      if (ns > 0 && k == sk0) do_strobe(sv0);
      if (ns > 1 && k == sk1) do_strobe(sv1);
      d = $urandom;
      l = (k < lim) ? ($urandom_range(0, 7) == 0) : 1'b0;
      if (pl_pass[k] && (kill_k < 0 || k < kill_k)) begin
        e = pl_exp[k];
        e.data = d;
        sb.push_back(e);
      end
      do_beat(d, l);
    end
    @(negedge clk);
    post_chk("drain", 64'(sb.size()), 64'd0);
    post_chk("idle_after_frame", 64'(o_frame_active), 64'd0);
  endtask

  initial begin
    int g, p, c, s, ns, sk0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    i_tvalid = 1'b1; i_tlast = 1'b0;
    #1;
    post_chk("rst_o_tvalid", 64'(o_tvalid), 64'd0);
    post_chk("rst_i_tready", 64'(i_tready), 64'd1);
    post_chk("rst_frame_active", 64'(o_frame_active), 64'd0);
    post_chk("rst_o_sof", 64'(o_sof), 64'd0);
    post_chk("rst_o_eof", 64'(o_eof), 64'd0);
    @(posedge clk); #1;
    i_tvalid = 1'b0;

    run_frame(4, 2, 16, 64, 1, 34, 3, 0, 0, -1, 0, 1'b0);
    run_frame(4, 2, 16, 64, 1, 34, 3, 0, 0, -1, 0, 1'b1);
    run_frame(0, 0, 0, 16, 0, 0, 0, 0, 0, -1, 0, 1'b1);
    run_frame(2, 1, 4, 8, 2, 65, 1, 67, 10, -1, 0, 1'b1);
    run_frame(3, 1, 4, 10, 0, 0, 0, 0, 0, 49, 1, 1'b1);
    run_frame(0, 0, 2, 5, 0, 0, 0, 0, 0, -1, 0, 1'b1);
    run_frame(2, 1, 8, 8, 0, 0, 0, 0, 0, 14, 2, 1'b1);
    run_frame(1, 0, 0, 0, 1, 0, 0, 0, 0, -1, 0, 1'b1);
    run_frame(0, 1, 3, 6, 1, 2, 15, 0, 0, -1, 0, 1'b1);

    for (int f = 0; f < 25; f++) begin
      g  = $urandom_range(0, 6);
      p  = $urandom_range(0, 2);
      c  = $urandom_range(0, 8);
      s  = $urandom_range(0, 20);
      ns = $urandom_range(0, 2);
      sk0 = $urandom_range(0, g + p * 20 + 60);
      run_frame(g, p, c, s, ns, sk0, $urandom_range(0, 15), sk0 + $urandom_range(1, 30),
                $urandom_range(0, 15), -2, 1, 1'b1);
    end

    repeat (3) @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
